cvsd_dec: RTL and testbench

- CVSD (adaptive delta modulation) decoder at the receive end of the 1-bit CVSD link.
- Consumes the encoder's comparator bit stream and rebuilds the 8-bit staircase estimate xp. Step adaptation and wrap arithmetic match the encoder, so xp tracks the encoder's xp bit-exactly when one bit is accepted per encoder clock.
- Adds a first-order IIR smoothing output, an output-valid strobe and a slope-overload indicator for the downstream DAC path.

---
 rtl/cvsd_dec_if.sv | 32 +++
 rtl/cvsd_dec.sv | 85 ++++++++
 tb/tb_cvsd_dec.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cvsd_dec_if.sv
// CVSD decoder bus: received bit stream in, reconstructed samples and status out.
interface cvsd_dec_if;
   logic       bit_in;
   logic       bit_valid;
   logic [7:0] xp;
   logic [7:0] y;
   logic       out_valid;
   logic       flag;
   logic       overload;

   // Bit source / sample consumer side
   modport master (
      output bit_in,
      output bit_valid,
      input  xp,
      input  y,
      input  out_valid,
      input  flag,
      input  overload
   );

   // Decoder side
   modport slave (
      input  bit_in,
      input  bit_valid,
      output xp,
      output y,
      output out_valid,
      output flag,
      output overload
   );
endinterface

// File: rtl/cvsd_dec.sv
// CVSD decoder: rebuilds the encoder's 8-bit staircase from the received bit
// stream, with a first-order IIR smoother and a slope-overload indicator.
module cvsd_dec #(
   parameter int unsigned beta      = 48,
   parameter int unsigned delta     = 1,
   parameter int unsigned step0     = 10,
   parameter int unsigned LPF_SHIFT = 2,
   parameter int unsigned OVL_TH    = 8
) (
   input  logic       clk_10k,
   input  logic       rst_n,
   cvsd_dec_if.slave  bus
);

   logic [7:0]        xp_q, xp_d;
   logic [7:0]        y_q, y_d;
   logic [7:0]        step_q, step_d;
   logic              h1_q, h2_q;
   logic [3:0]        run_q, run_d;
   logic              ovl_q, ovl_d;
   logic              vld_q;
   logic              flag;
   logic [15:0]       prod;
   logic [15:0]       quot;
   logic signed [8:0] diff;
   logic signed [8:0] diff_sh;

   // Run detect and next-state arithmetic for an accepted bit
   always_comb begin
      flag    = bus.bit_valid && (bus.bit_in == h1_q) && (bus.bit_in == h2_q);
      // Step decay: beta/50 with a truncating divide, then truncated to 8 bits
      prod    = 16'(beta) * {8'd0, step_q};
      quot    = prod / 16'd50;
      step_d  = 8'(quot + (flag ? 16'(delta) : 16'd0));
      // Staircase wraps modulo 256, same as the encoder
      xp_d    = bus.bit_in ? (xp_q + step_q) : (xp_q - step_q);
      // Both operands are non-negative, so the 9-bit signed difference is exact
      diff    = $signed({1'b0, xp_d}) - $signed({1'b0, y_q});
      diff_sh = diff >>> LPF_SHIFT;
      y_d     = 8'({1'b0, y_q} + $unsigned(diff_sh));
      if (!flag) begin
         run_d = 4'd0;
      end else if (run_q == 4'd15) begin
         run_d = 4'd15;
      end else begin
         run_d = run_q + 4'd1;
      end
      ovl_d   = (run_d >= 4'(OVL_TH));
   end

   // State update; everything except the valid strobe holds when no bit arrives
   always_ff @(posedge clk_10k or negedge rst_n) begin
      if (!rst_n) begin
         xp_q   <= 8'd128;
         y_q    <= 8'd128;
         step_q <= 8'(step0);
         h1_q   <= 1'b1;
         h2_q   <= 1'b0;
         run_q  <= 4'd0;
         ovl_q  <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= bus.bit_valid;
         if (bus.bit_valid) begin
            xp_q   <= xp_d;
            y_q    <= y_d;
            step_q <= step_d;
            h1_q   <= bus.bit_in;
            h2_q   <= h1_q;
            run_q  <= run_d;
            ovl_q  <= ovl_d;
         end
      end
   end

   // Output mapping
   always_comb begin
      bus.xp        = xp_q;
      bus.y         = y_q;
      bus.out_valid = vld_q;
      bus.flag      = flag;
      bus.overload  = ovl_q;
   end

endmodule

// File: tb/tb_cvsd_dec.sv
// Self-checking bench for cvsd_dec: directed vector table, random stream and
// sine loopback against an arithmetic reference model.
module tb_cvsd_dec;

   localparam int BETA  = 48;
   localparam int DELTA = 1;
   localparam int STEP0 = 10;
   localparam int LPF   = 2;
   localparam int OVTH  = 8;

   logic clk_10k = 1'b0;
   logic rst_n   = 1'b0;

   cvsd_dec_if bus ();

   cvsd_dec #(
      .beta      (BETA),
      .delta     (DELTA),
      .step0     (STEP0),
      .LPF_SHIFT (LPF),
      .OVL_TH    (OVTH)
   ) dut (
      .clk_10k (clk_10k),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #50 clk_10k = ~clk_10k;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_xp, m_y, m_step, m_h1, m_h2, m_run, m_ov, m_vld;

   typedef struct {
      bit rst;
      bit bv;
      bit bi;
      int xp;
      int flag;
      int y;
      int ov;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_xp = 128; m_y = 128; m_step = STEP0;
      m_h1 = 1; m_h2 = 0; m_run = 0; m_ov = 0; m_vld = 0;
   endfunction

   function automatic int model_flag(input bit bv, input bit bi);
      return (bv && (int'(bi) == m_h1) && (int'(bi) == m_h2)) ? 1 : 0;
   endfunction

   function automatic void model_clock(input bit bv, input bit bi);
      int f, nxt, d;
      if (!bv) begin
         m_vld = 0;
         return;
      end
      f      = model_flag(bv, bi);
      nxt    = bi ? (m_xp + m_step) : (m_xp - m_step);
      nxt    = nxt & 255;
      d      = nxt - m_y;
      m_y    = (m_y + (d >>> LPF)) & 255;
      m_step = ((((BETA * m_step) / 50) & 255) + (f != 0 ? DELTA : 0)) & 255;
      m_run  = (f != 0) ? ((m_run + 1 > 15) ? 15 : m_run + 1) : 0;
      m_ov   = (m_run >= OVTH) ? 1 : 0;
      m_h2   = m_h1;
      m_h1   = int'(bi);
      m_xp   = nxt;
      m_vld  = 1;
   endfunction

   // Asynchronous reset pulse away from the clock edge; outputs must drop at once
   task automatic do_reset();
      @(negedge clk_10k);
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_xp", int'(bus.xp), 128);
      check("rst_y", int'(bus.y), 128);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_overload", int'(bus.overload), 0);
      model_reset();
      #5;
      rst_n = 1'b1;
   endtask

   // One clock: drive, check the combinational flag, clock, check registered outputs.
   // Table expectations of -1 are not checked directly (the model still is).
   task automatic apply(input bit bv, input bit bi, input int exp_xp, input int exp_flag,
                        input int exp_y, input int exp_ov);
      @(negedge clk_10k);
      bus.bit_valid = bv;
      bus.bit_in    = bi;
      #1;
      check("flag_model", int'(bus.flag), model_flag(bv, bi));
      if (exp_flag >= 0) check("flag_table", int'(bus.flag), exp_flag);
      model_clock(bv, bi);
      @(posedge clk_10k);
      #1;
      check("xp_model", int'(bus.xp), m_xp);
      check("y_model", int'(bus.y), m_y);
      check("out_valid", int'(bus.out_valid), m_vld);
      check("overload_model", int'(bus.overload), m_ov);
      if (exp_xp >= 0) check("xp_table", int'(bus.xp), exp_xp);
      if (exp_y >= 0) check("y_table", int'(bus.y), exp_y);
      if (exp_ov >= 0) check("overload_table", int'(bus.overload), exp_ov);
   endtask

   function automatic void add(input bit rst, input bit bv, input bit bi, input int xp,
                               input int flag, input int y, input int ov);
      vec_t v;
      v.rst = rst; v.bv = bv; v.bi = bi; v.xp = xp; v.flag = flag; v.y = y; v.ov = ov;
      tbl.push_back(v);
   endfunction

   function automatic void add_rst();
      add(1'b1, 1'b0, 1'b0, -1, -1, -1, -1);
   endfunction

   initial begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
      model_reset();

      // Three 1s after reset
      add_rst();
      add(0, 1, 1, 138, 0, 130, 0);
      add(0, 1, 1, 147, 1, -1, 0);
      add(0, 1, 1, 156, 1, -1, 0);

      // Alternating bits decay the step to zero, then a run of 1s revives it
      add_rst();
      add(0, 1, 0, 118, 0, -1, 0);
      add(0, 1, 1, 127, 0, -1, 0);
      add(0, 1, 0, 119, 0, -1, 0);
      add(0, 1, 1, 126, 0, -1, 0);
      add(0, 1, 0, 120, 0, -1, 0);
      add(0, 1, 1, 125, 0, -1, 0);
      add(0, 1, 0, 121, 0, -1, 0);
      add(0, 1, 1, 124, 0, -1, 0);
      add(0, 1, 0, 122, 0, -1, 0);
      add(0, 1, 1, 123, 0, -1, 0);
      add(0, 1, 0, 123, 0, -1, 0);
      add(0, 1, 1, 123, 0, -1, 0);
      add(0, 1, 1, 123, 0, -1, 0);
      add(0, 1, 1, 123, 1, -1, 0);
      add(0, 1, 1, 124, 1, -1, 0);

      // Fifteen 1s: wrap past 255 and overload from the 9th bit
      add_rst();
      for (int n = 1; n <= 15; n++) begin
         add(0, 1, 1, (138 + 9 * (n - 1)) % 256, (n > 1) ? 1 : 0, -1, (n >= 9) ? 1 : 0);
      end

      // Gap of five idle cycles mid-stream
      add_rst();
      add(0, 1, 1, 138, 0, -1, 0);
      add(0, 1, 1, 147, 1, -1, 0);
      for (int n = 0; n < 5; n++) add(0, 0, n[0], 147, 0, -1, 0);
      add(0, 1, 1, 156, 1, -1, 0);

      // Reset mid-run of 1s
      add_rst();
      add(0, 1, 1, 138, 0, -1, 0);
      add(0, 1, 1, 147, 1, -1, 0);
      add(0, 1, 1, 156, 1, -1, 0);
      add(0, 1, 1, 165, 1, -1, 0);
      add_rst();
      add(0, 1, 1, 138, 0, 130, 0);

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         else apply(tbl[i].bv, tbl[i].bi, tbl[i].xp, tbl[i].flag, tbl[i].y, tbl[i].ov);
      end

      // Random stream with gaps and biased runs
      do_reset();
      begin
         bit last = 1'b0;
         for (int n = 0; n < 600; n++) begin
            bit bv, bi;
            bv = ($urandom_range(0, 3) != 0);
            bi = ($urandom_range(0, 4) == 0) ? ~last : last;
            if ($urandom_range(0, 40) == 0) bi = $urandom_range(0, 1);
            if (bv) last = bi;
            apply(bv, bi, -1, -1, -1, -1);
         end
      end

      // Loopback: model acts as encoder on a sine, decoder must track its xp
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         real s;
         int  x;
         bit  bi;
         s  = 128.0 + 100.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 200.0);
         x  = int'(s);
         bi = (x >= m_xp);
         apply(1'b1, bi, -1, -1, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
